mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the CPU side (pulse unit read strobes, op write-backs) and the io unit (tape load / console examine-deposit).
- Captures one-cycle request pulses and arbitrates round-robin when both sides are pending.
- Sequences each access through a fixed-latency memory cycle and returns a one-cycle reply pulse with registered read data to the owning requester.

Parameters:
ADDR_W, 11, memory address width
DATA_W, 31, memory word width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (legal range 1..7)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
cpu_req  input  1  pulse, CPU access request
cpu_we  input  1  qualifies cpu_req: 1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address, sampled with cpu_req
cpu_wdata  input  DATA_W  CPU write data, sampled with cpu_req
cpu_reply  output  1  pulse, CPU access complete
cpu_rdata  output  DATA_W  CPU read data, held until next CPU read completes
cpu_busy  output  1  level, CPU request queued or in flight
cpu_ovf  output  1  sticky, CPU request dropped
io_req  input  1  pulse, io access request
io_we  input  1  qualifies io_req: 1 = write, 0 = read
io_addr  input  ADDR_W  io address, sampled with io_req
io_wdata  input  DATA_W  io write data, sampled with io_req
io_reply  output  1  pulse, io access complete
io_rdata  output  DATA_W  io read data, held until next io read completes
io_busy  output  1  level, io request queued or in flight
io_ovf  output  1  sticky, io request dropped
mem_en  output  1  one-cycle memory strobe
mem_we  output  1  write qualifier for mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
Clock and reset:
- One clock: clk.
- Reset is asynchronous and active-low on resetn.
- While resetn is low, all outputs, pending flags, state and counter are 0; last_grant = IO, so the CPU wins the first tie.
- Reset mid-access aborts the access immediately: mem_en drops and no reply is issued.

Request capture (per requester):
- A req pulse with the pending flag clear latches we/addr/wdata into that side's pending registers at the clock edge.
- A req pulse while pending is already set: the request is dropped, the first request is kept, and ovf is set (cleared only by reset).
- Pending clears on the edge its request is granted, so a side may hold one request in flight plus one queued.
- busy = pending | (in flight and owner == that side).

FSM IDLE -> ACCESS -> WAIT -> DONE -> IDLE:
- IDLE:
  - Only one side pending: grant it.
  - Both pending: grant the side != last_grant.
  - On grant: latch owner, we, addr, wdata; set last_grant = owner; go to ACCESS.
- ACCESS: mem_en = 1 for exactly one cycle with mem_we/mem_addr/mem_wdata from the latched values. Load counter = MEM_LAT-1. Go to WAIT, or directly to DONE if MEM_LAT = 1.
- WAIT: decrement the counter each cycle; go to DONE when it reaches 1.
- DONE:
  - mem_rdata is valid in this cycle.
  - On a read, the owner's rdata register loads mem_rdata.
  - The owner's reply register is set (read or write) and reads high for exactly one cycle, the cycle after DONE.
  - Go to IDLE.
- Outside ACCESS, mem_en = 0 and mem_we = 0. mem_addr/mem_wdata hold the last latched values.

Timing:
- Request pulse in cycle 0 -> pending in cycle 1 -> ACCESS in cycle 2 -> DONE in cycle 2+MEM_LAT -> reply in cycle 3+MEM_LAT.
- MEM_LAT = 2 gives reply in cycle 5.
- One access occupies the port for MEM_LAT+2 cycles (IDLE arbitration cycle included).

Simultaneous events:
- A req pulse in the same cycle as that side's reply is accepted normally.
- Both req pulses in the same cycle: both are latched; the tie is resolved by last_grant.
- A write reply leaves rdata unchanged.
- A CPU request queued while an IO access is in flight is served on the next IDLE cycle.
- Worst-case wait for either side is one foreign access.

Test Plan:
1. Reset, MEM_LAT=2, CPU read of addr 0x005 with memory model word 0x1234567: mem_en cycle 2 with addr 0x005; cpu_reply high cycle 5 only; cpu_rdata=0x1234567; io_reply never high.
2. IO write of 0x7FFFFFFF to 0x7FF: mem_en & mem_we cycle 2 with addr/data; io_reply cycle 5; io_rdata unchanged; a later CPU read of 0x7FF returns 0x7FFFFFFF.
3. cpu_req and io_req (both reads) in the same cycle directly after reset: CPU granted first (reply cycle 5); IO mem_en cycle 6, io_reply cycle 9. A second simultaneous pair is then served IO first.
4. CPU request pulsed, then a second CPU request while the first is still pending (before grant): second dropped; cpu_ovf=1 and stays 1; only one access occurs. A request issued after the grant is queued and served without ovf.
5. resetn driven low during WAIT of a CPU read: mem_en, replies, busy and ovf are 0 immediately. After release, no stale reply appears and a new IO read completes at cycle 5.
6. MEM_LAT=1 and MEM_LAT=7 builds: CPU read reply at cycles 4 and 10 respectively, with correct data; 20 alternating back-to-back requests show strict alternation and no loss.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between the CPU side and
// the io unit. One-deep request capture per side, round-robin on ties, and a
// one-cycle reply pulse with registered read data back to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 31,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_reply,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_ovf,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_reply,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_busy,
  output logic              io_ovf,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 3;
  localparam logic SIDE_CPU = 1'b0;
  localparam logic SIDE_IO  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;
  logic                grant;

  logic                cpu_pend_q, cpu_pend_d, cpu_pwe_q, cpu_pwe_d;
  logic [ADDR_W-1:0]   cpu_paddr_q, cpu_paddr_d;
  logic [DATA_W-1:0]   cpu_pwdata_q, cpu_pwdata_d;
  logic                io_pend_q, io_pend_d, io_pwe_q, io_pwe_d;
  logic [ADDR_W-1:0]   io_paddr_q, io_paddr_d;
  logic [DATA_W-1:0]   io_pwdata_q, io_pwdata_d;

  logic                cpu_ovf_q, cpu_ovf_d, io_ovf_q, io_ovf_d;
  logic                cpu_reply_q, cpu_reply_d, io_reply_q, io_reply_d;
  logic                cpu_busy_q, cpu_busy_d, io_busy_q, io_busy_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, io_rdata_q, io_rdata_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;

  // Next-state: arbitration, access sequencing, request capture and outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_d       = last_q;
    acc_we_d     = acc_we_q;
    acc_addr_d   = acc_addr_q;
    acc_wdata_d  = acc_wdata_q;
    grant        = 1'b0;
    cpu_pend_d   = cpu_pend_q;
    cpu_pwe_d    = cpu_pwe_q;
    cpu_paddr_d  = cpu_paddr_q;
    cpu_pwdata_d = cpu_pwdata_q;
    io_pend_d    = io_pend_q;
    io_pwe_d     = io_pwe_q;
    io_paddr_d   = io_paddr_q;
    io_pwdata_d  = io_pwdata_q;
    cpu_ovf_d    = cpu_ovf_q;
    io_ovf_d     = io_ovf_q;
    cpu_rdata_d  = cpu_rdata_q;
    io_rdata_d   = io_rdata_q;
    cpu_reply_d  = 1'b0;
    io_reply_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_pend_q || io_pend_q) begin
          grant = 1'b1;
          if (cpu_pend_q && io_pend_q) owner_d = ~last_q;
          else                         owner_d = io_pend_q ? SIDE_IO : SIDE_CPU;
          last_d = owner_d;
          if (owner_d == SIDE_IO) begin
            acc_we_d    = io_pwe_q;
            acc_addr_d  = io_paddr_q;
            acc_wdata_d = io_pwdata_q;
          end else begin
            acc_we_d    = cpu_pwe_q;
            acc_addr_d  = cpu_paddr_q;
            acc_wdata_d = cpu_pwdata_q;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        // mem_rdata is valid exactly in this cycle
        if (owner_q == SIDE_CPU) begin
          cpu_reply_d = 1'b1;
          if (!acc_we_q) cpu_rdata_d = mem_rdata;
        end else begin
          io_reply_d = 1'b1;
          if (!acc_we_q) io_rdata_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Granted request leaves the queue; a new pulse only lands in an empty slot
    if (grant && owner_d == SIDE_CPU) cpu_pend_d = 1'b0;
    if (grant && owner_d == SIDE_IO)  io_pend_d  = 1'b0;
    if (cpu_req) begin
      if (!cpu_pend_q) begin
        cpu_pend_d   = 1'b1;
        cpu_pwe_d    = cpu_we;
        cpu_paddr_d  = cpu_addr;
        cpu_pwdata_d = cpu_wdata;
      end else begin
        cpu_ovf_d = 1'b1;
      end
    end
    if (io_req) begin
      if (!io_pend_q) begin
        io_pend_d   = 1'b1;
        io_pwe_d    = io_we;
        io_paddr_d  = io_addr;
        io_pwdata_d = io_wdata;
      end else begin
        io_ovf_d = 1'b1;
      end
    end

    mem_en_d   = grant;
    mem_we_d   = grant & acc_we_d;
    cpu_busy_d = cpu_pend_d | ((state_d != IDLE) && (owner_d == SIDE_CPU));
    io_busy_d  = io_pend_d  | ((state_d != IDLE) && (owner_d == SIDE_IO));
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= SIDE_CPU;
      last_q       <= SIDE_IO;
      acc_we_q     <= 1'b0;
      acc_addr_q   <= '0;
      acc_wdata_q  <= '0;
      cpu_pend_q   <= 1'b0;
      cpu_pwe_q    <= 1'b0;
      cpu_paddr_q  <= '0;
      cpu_pwdata_q <= '0;
      io_pend_q    <= 1'b0;
      io_pwe_q     <= 1'b0;
      io_paddr_q   <= '0;
      io_pwdata_q  <= '0;
      cpu_ovf_q    <= 1'b0;
      io_ovf_q     <= 1'b0;
      cpu_reply_q  <= 1'b0;
      io_reply_q   <= 1'b0;
      cpu_busy_q   <= 1'b0;
      io_busy_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      io_rdata_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      acc_we_q     <= acc_we_d;
      acc_addr_q   <= acc_addr_d;
      acc_wdata_q  <= acc_wdata_d;
      cpu_pend_q   <= cpu_pend_d;
      cpu_pwe_q    <= cpu_pwe_d;
      cpu_paddr_q  <= cpu_paddr_d;
      cpu_pwdata_q <= cpu_pwdata_d;
      io_pend_q    <= io_pend_d;
      io_pwe_q     <= io_pwe_d;
      io_paddr_q   <= io_paddr_d;
      io_pwdata_q  <= io_pwdata_d;
      cpu_ovf_q    <= cpu_ovf_d;
      io_ovf_q     <= io_ovf_d;
      cpu_reply_q  <= cpu_reply_d;
      io_reply_q   <= io_reply_d;
      cpu_busy_q   <= cpu_busy_d;
      io_busy_q    <= io_busy_d;
      cpu_rdata_q  <= cpu_rdata_d;
      io_rdata_q   <= io_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign cpu_reply = cpu_reply_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_busy  = cpu_busy_q;
  assign cpu_ovf   = cpu_ovf_q;
  assign io_reply  = io_reply_q;
  assign io_rdata  = io_rdata_q;
  assign io_busy   = io_busy_q;
  assign io_ovf    = io_ovf_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = acc_addr_q;
  assign mem_wdata = acc_wdata_q;

endmodule
